hex_line_printer: RTL and testbench

Parametrised multi-channel hex formatter feeding the UART transmit path.
- On an input strobe it latches CHANNELS words of WIDTH bits each.
- It then streams one ASCII line into a byte-wide UART TX FIFO interface: per channel, lowercase hex digits; channels separated by a space; line terminated by "\r\n".
- Replaces ad-hoc per-design hex printing loops (pulse timers, counters, sensor dumps). Adds a ready-based throttle so the FIFO is never overrun.

---
 rtl/hex_print_pkg.sv | 21 ++
 rtl/hex_nibble_to_ascii.sv | 14 +
 rtl/hex_line_printer.sv | 146 ++++++++++++++
 tb/tb_hex_line_printer.sv | 304 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/hex_print_pkg.sv
// Shared constants for the hex print blocks: ASCII codes, FSM state encoding,
// and the hex digit count helper.
package hex_print_pkg;

  localparam logic [7:0] ASC_SPACE = 8'h20;
  localparam logic [7:0] ASC_CR    = 8'h0d;
  localparam logic [7:0] ASC_LF    = 8'h0a;
  localparam logic [7:0] ASC_0     = 8'h30;
  localparam logic [7:0] ASC_A_LC  = 8'h61;

  localparam logic [2:0] ST_IDLE  = 3'd0;
  localparam logic [2:0] ST_DIGIT = 3'd1;
  localparam logic [2:0] ST_SEP   = 3'd2;
  localparam logic [2:0] ST_CR    = 3'd3;
  localparam logic [2:0] ST_LF    = 3'd4;

  function automatic int hex_digits(input int width);
    return (width + 3) / 4;
  endfunction

endpackage

// File: rtl/hex_nibble_to_ascii.sv
// Combinational 4-bit value to lowercase ASCII hex digit.
module hex_nibble_to_ascii
  import hex_print_pkg::*;
(
  input  logic [3:0] nibble_i,
  output logic [7:0] ascii_o
);

  always_comb begin
    if (nibble_i < 4'd10) ascii_o = ASC_0 + {4'h0, nibble_i};
    else                  ascii_o = ASC_A_LC + {4'h0, nibble_i} - 8'd10;
  end

endmodule

// File: rtl/hex_line_printer.sv
// Latches CHANNELS words on in_strobe and streams "hhhh hhhh\r\n" to a UART TX FIFO.
// Optional HEX_LINE_PRINTER_ZERO_SUPPRESS_EN skips leading zero digits per channel.
//
// Handshake: a byte transfers in any cycle where the FSM has a byte pending and
// uart_ready=1; uart_strobe is asserted only in those cycles and the FSM advances.
module hex_line_printer
  import hex_print_pkg::*;
#(
  parameter int WIDTH    = 32,
  parameter int CHANNELS = 1
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic [CHANNELS*WIDTH-1:0] in_data,
  input  logic                      in_strobe,
  output logic                      busy,
  output logic                      dropped,
  output logic [7:0]                uart_data,
  output logic                      uart_strobe,
  input  logic                      uart_ready,
  output logic [2:0]                dbg_state_o
);

  localparam int D  = hex_digits(WIDTH);
  localparam int NW = (D > 1) ? $clog2(D) : 1;
  localparam int CW = (CHANNELS > 1) ? $clog2(CHANNELS) : 1;
  localparam int TW = CHANNELS * WIDTH;
  localparam logic [NW-1:0] NIB_LAST = NW'(D - 1);
  localparam logic [CW-1:0] CH_LAST  = CW'(CHANNELS - 1);

  logic [2:0]    state_q, state_d;
  logic [TW-1:0] shift_q, shift_d;
  logic [NW-1:0] nib_q, nib_d;
  logic [CW-1:0] ch_q, ch_d;
  logic          dropped_q, dropped_d;

  logic [TW-1:0]  shift_nx;
  logic [4*D-1:0] cur_pad;
  logic [3:0]     cur_nib;
  logic [7:0]     digit_ascii;
  logic [7:0]     byte_c;
  logic [NW-1:0]  start_in, start_nx;

  // The channel being printed always sits in the low WIDTH bits of shift_q.
  assign shift_nx = shift_q >> WIDTH;

  always_comb begin
    cur_pad = '0;
    cur_pad[WIDTH-1:0] = shift_q[WIDTH-1:0];
  end

  assign cur_nib = cur_pad[{nib_q, 2'b00} +: 4];

  hex_nibble_to_ascii u_nib2asc (
    .nibble_i (cur_nib),
    .ascii_o  (digit_ascii)
  );

`ifdef HEX_LINE_PRINTER_ZERO_SUPPRESS_EN
  // Starting nibble is the highest non-zero one, or 0 so a zero word prints "0".
  logic [4*D-1:0] in_pad, nx_pad;
  always_comb begin
    in_pad = '0;
    in_pad[WIDTH-1:0] = in_data[WIDTH-1:0];
    nx_pad = '0;
    nx_pad[WIDTH-1:0] = shift_nx[WIDTH-1:0];
    start_in = '0;
    start_nx = '0;
    for (int i = 0; i < D; i++) begin
      if (in_pad[4*i +: 4] != 4'h0) start_in = NW'(i);
      if (nx_pad[4*i +: 4] != 4'h0) start_nx = NW'(i);
    end
  end
`else
  assign start_in = NIB_LAST;
  assign start_nx = NIB_LAST;
`endif

  always_comb begin
    state_d   = state_q;
    shift_d   = shift_q;
    nib_d     = nib_q;
    ch_d      = ch_q;
    dropped_d = in_strobe && (state_q != ST_IDLE);
    byte_c    = 8'h00;
    case (state_q)
      ST_IDLE: begin
        if (in_strobe) begin
          shift_d = in_data;
          ch_d    = '0;
          nib_d   = start_in;
          state_d = ST_DIGIT;
        end
      end
      ST_DIGIT: begin
        byte_c = digit_ascii;
        if (uart_ready) begin
          if (nib_q == '0) state_d = (ch_q == CH_LAST) ? ST_CR : ST_SEP;
          else             nib_d   = nib_q - 1'b1;
        end
      end
      ST_SEP: begin
        byte_c = ASC_SPACE;
        if (uart_ready) begin
          ch_d    = ch_q + 1'b1;
          shift_d = shift_nx;
          nib_d   = start_nx;
          state_d = ST_DIGIT;
        end
      end
      ST_CR: begin
        byte_c = ASC_CR;
        if (uart_ready) state_d = ST_LF;
      end
      ST_LF: begin
        byte_c = ASC_LF;
        if (uart_ready) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= ST_IDLE;
      shift_q   <= '0;
      nib_q     <= '0;
      ch_q      <= '0;
      dropped_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      shift_q   <= shift_d;
      nib_q     <= nib_d;
      ch_q      <= ch_d;
      dropped_q <= dropped_d;
    end
  end

  // Gating with reset makes a mid-line reset silence the output in its own cycle.
  assign busy        = (state_q != ST_IDLE);
  assign dropped     = dropped_q;
  assign uart_strobe = !reset && uart_ready && (state_q != ST_IDLE);
  assign uart_data   = reset ? 8'h00 : byte_c;
  assign dbg_state_o = state_q;

endmodule

// File: tb/tb_hex_line_printer.sv
// Scoreboard bench for hex_line_printer: DUT A (16-bit x 2) and DUT B (10-bit x 1).
// Expected behaviour follows HEX_LINE_PRINTER_ZERO_SUPPRESS_EN when defined.
module tb_hex_line_printer;
  import hex_print_pkg::*;

  localparam int WA = 16, CA = 2, WB = 10, CB = 1;
`ifdef HEX_LINE_PRINTER_ZERO_SUPPRESS_EN
  localparam int T1_LEN = 9;
`else
  localparam int T1_LEN = 11;
`endif

  // clock / reset
  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic reset_a, in_strobe_a, uart_ready_a, busy_a, dropped_a, uart_strobe_a;
  logic [WA*CA-1:0] in_data_a;
  logic [7:0] uart_data_a;
  logic [2:0] dbg_state_a;
  logic reset_b, in_strobe_b, uart_ready_b, busy_b, dropped_b, uart_strobe_b;
  logic [WB*CB-1:0] in_data_b;
  logic [7:0] uart_data_b;
  logic [2:0] dbg_state_b;

  hex_line_printer #(.WIDTH(WA), .CHANNELS(CA)) u_dut_a (
    .clk(clk), .reset(reset_a), .in_data(in_data_a), .in_strobe(in_strobe_a),
    .busy(busy_a), .dropped(dropped_a), .uart_data(uart_data_a),
    .uart_strobe(uart_strobe_a), .uart_ready(uart_ready_a), .dbg_state_o(dbg_state_a)
  );

  hex_line_printer #(.WIDTH(WB), .CHANNELS(CB)) u_dut_b (
    .clk(clk), .reset(reset_b), .in_data(in_data_b), .in_strobe(in_strobe_b),
    .busy(busy_b), .dropped(dropped_b), .uart_data(uart_data_b),
    .uart_strobe(uart_strobe_b), .uart_ready(uart_ready_b), .dbg_state_o(dbg_state_b)
  );

  int n_cmp = 0;
  int n_err = 0;
  logic [7:0] exp_a_q[$];
  logic [7:0] exp_b_q[$];
  int byte_cnt_a = 0, byte_cnt_b = 0, dropped_cnt_a = 0, dropped_cnt_b = 0;
  int ready_mode_a = 0, ready_mode_b = 0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // reference model: builds the expected ASCII line for one strobe
  task automatic push_line(input int which, input logic [63:0] d, input int w,
                           input int ch, output int len);
    int dg, first;
    logic [63:0] word;
    logic [3:0] nib;
    logic [7:0] c;
    logic [7:0] line[$];
    dg = (w + 3) / 4;
    for (int k = 0; k < ch; k++) begin
      word = (d >> (k * w)) & ((64'd1 << w) - 64'd1);
      first = dg - 1;
`ifdef HEX_LINE_PRINTER_ZERO_SUPPRESS_EN
      first = 0;
      for (int i = 0; i < dg; i++) if (((word >> (4 * i)) & 64'hf) != 0) first = i;
`endif
      for (int i = first; i >= 0; i--) begin
        nib = 4'((word >> (4 * i)) & 64'hf);
        c = (nib < 4'd10) ? (8'h30 + 8'(nib)) : (8'h61 + 8'(nib) - 8'd10);
        line.push_back(c);
      end
      if (k < ch - 1) line.push_back(8'h20);
    end
    line.push_back(8'h0d);
    line.push_back(8'h0a);
    len = line.size();
    foreach (line[i]) begin
      if (which == 0) exp_a_q.push_back(line[i]);
      else            exp_b_q.push_back(line[i]);
    end
  endtask

  // uart_ready drivers: 0 = always ready, 1 = pattern 1,0,0, 2 = random
  initial begin
    int phase;
    phase = 0;
    uart_ready_a = 1'b1;
    uart_ready_b = 1'b1;
    forever begin
      @(posedge clk);
      #1;
      phase++;
      case (ready_mode_a)
        1:       uart_ready_a = (phase % 3 == 0);
        2:       uart_ready_a = 1'($urandom_range(0, 1));
        default: uart_ready_a = 1'b1;
      endcase
      case (ready_mode_b)
        1:       uart_ready_b = (phase % 3 == 0);
        2:       uart_ready_b = 1'($urandom_range(0, 1));
        default: uart_ready_b = 1'b1;
      endcase
    end
  end

  // scoreboard monitors
  always @(negedge clk) begin
    if (dropped_a) dropped_cnt_a++;
    if (uart_strobe_a) begin
      byte_cnt_a++;
      check("a_strobe_with_ready", uart_ready_a, 1);
      check("a_byte_expected", exp_a_q.size() != 0, 1);
      if (exp_a_q.size() != 0) check("a_byte", uart_data_a, exp_a_q.pop_front());
    end
  end

  always @(negedge clk) begin
    if (dropped_b) dropped_cnt_b++;
    if (uart_strobe_b) begin
      byte_cnt_b++;
      check("b_strobe_with_ready", uart_ready_b, 1);
      check("b_byte_expected", exp_b_q.size() != 0, 1);
      if (exp_b_q.size() != 0) check("b_byte", uart_data_b, exp_b_q.pop_front());
    end
  end

  // driver tasks
  task automatic strobe_a(input logic [WA*CA-1:0] d, input bit accept, output int len);
    in_data_a = d;
    in_strobe_a = 1'b1;
    len = 0;
    if (accept) push_line(0, 64'(d), WA, CA, len);
    @(posedge clk);
    #1;
    in_strobe_a = 1'b0;
  endtask

  task automatic strobe_b(input logic [WB*CB-1:0] d, output int len);
    in_data_b = d;
    in_strobe_b = 1'b1;
    push_line(1, 64'(d), WB, CB, len);
    @(posedge clk);
    #1;
    in_strobe_b = 1'b0;
  endtask

  task automatic wait_idle_a(input int exp_busy, input string tag);
    int n;
    bit done;
    n = 0;
    done = 1'b0;
    for (int i = 0; i < 400 && !done; i++) begin
      @(negedge clk);
      if (busy_a) n++;
      else done = 1'b1;
    end
    check({tag, "_idle"}, done, 1);
    if (exp_busy >= 0) check({tag, "_busy_cycles"}, n, exp_busy);
    check({tag, "_queue_empty"}, exp_a_q.size(), 0);
    @(posedge clk);
    #1;
  endtask

  task automatic wait_idle_b(input int exp_busy, input string tag);
    int n;
    bit done;
    n = 0;
    done = 1'b0;
    for (int i = 0; i < 400 && !done; i++) begin
      @(negedge clk);
      if (busy_b) n++;
      else done = 1'b1;
    end
    check({tag, "_idle"}, done, 1);
    if (exp_busy >= 0) check({tag, "_busy_cycles"}, n, exp_busy);
    check({tag, "_queue_empty"}, exp_b_q.size(), 0);
    @(posedge clk);
    #1;
  endtask

  initial begin
    #300000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int len, saved;
    bit hit;
    reset_a = 1'b1; reset_b = 1'b1;
    in_strobe_a = 1'b0; in_strobe_b = 1'b0;
    in_data_a = '0; in_data_b = '0;
    repeat (3) @(posedge clk);
    #1;
    reset_a = 1'b0; reset_b = 1'b0;
    @(negedge clk);
    check("rst_busy", busy_a, 0);
    check("rst_dropped", dropped_a, 0);
    check("rst_uart_strobe", uart_strobe_a, 0);
    check("rst_uart_data", uart_data_a, 8'h00);
    check("rst_state", dbg_state_a, ST_IDLE);
    check("rst_busy_b", busy_b, 0);
    @(posedge clk);
    #1;

    // basic line, ready held high
    strobe_a({16'h00a5, 16'h1234}, 1'b1, len);
    wait_idle_a(T1_LEN, "t1");

    // backpressure 1,0,0
    ready_mode_a = 1;
    strobe_a({16'h00a5, 16'h1234}, 1'b1, len);
    wait_idle_a(-1, "t2");
    ready_mode_a = 0;
    @(posedge clk);
    #1;

    // overflow: second strobe three cycles after the first is dropped
    dropped_cnt_a = 0;
    strobe_a({16'hbeef, 16'h0042}, 1'b1, len);
    @(posedge clk); #1;
    @(posedge clk); #1;
    strobe_a({16'hdead, 16'hf00d}, 1'b0, len);
    wait_idle_a(-1, "t3");
    check("t3_dropped_once", dropped_cnt_a, 1);
    strobe_a({16'hdead, 16'hf00d}, 1'b1, len);
    wait_idle_a(len, "t3_new");

    // strobe in the first idle cycle after LF is accepted
    strobe_a({16'h7777, 16'h0001}, 1'b1, len);
    hit = 1'b0;
    for (int i = 0; i < 100 && !hit; i++) begin
      @(negedge clk);
      if (!busy_a) hit = 1'b1;
    end
    check("t3b_found_idle", hit, 1);
    in_data_a = {16'h00ff, 16'hc0de};
    in_strobe_a = 1'b1;
    push_line(0, 64'(in_data_a), WA, CA, len);
    @(posedge clk);
    #1;
    in_strobe_a = 1'b0;
    wait_idle_a(len, "t3b");
    check("t3b_no_drop", dropped_cnt_a, 1);

    // reset after the fifth byte aborts the line
    byte_cnt_a = 0;
    strobe_a({16'h5678, 16'h9abc}, 1'b1, len);
    hit = 1'b0;
    for (int i = 0; i < 100 && !hit; i++) begin
      if (byte_cnt_a >= 5) hit = 1'b1;
      else begin @(posedge clk); #1; end
    end
    check("t4_reached_5", hit, 1);
    reset_a = 1'b1;
    exp_a_q.delete();
    @(negedge clk);
    check("t4_strobe_in_reset", uart_strobe_a, 0);
    @(posedge clk);
    #1;
    reset_a = 1'b0;
    @(negedge clk);
    check("t4_busy_after_reset", busy_a, 0);
    check("t4_state_after_reset", dbg_state_a, ST_IDLE);
    saved = byte_cnt_a;
    repeat (3) @(negedge clk);
    check("t4_no_more_bytes", byte_cnt_a, saved);
    check("t4_bytes_before_reset", saved, 5);
    @(posedge clk);
    #1;
    strobe_a({16'h0000, 16'h0000}, 1'b1, len);
    wait_idle_a(len, "t4_fresh");

    // odd width on DUT B
    strobe_b(10'h3ff, len);
    wait_idle_b(len, "t5_3ff");
    strobe_b(10'h005, len);
    wait_idle_b(len, "t5_005");
    strobe_b(10'h000, len);
    wait_idle_b(len, "t5_000");
    check("t5_no_drop", dropped_cnt_b, 0);

    // random data under random backpressure
    ready_mode_a = 2;
    ready_mode_b = 2;
    for (int n = 0; n < 6; n++) begin
      strobe_a(32'($urandom()), 1'b1, len);
      wait_idle_a(-1, "t6_rand_a");
      strobe_b(10'($urandom_range(0, 1023)), len);
      wait_idle_b(-1, "t6_rand_b");
    end
    ready_mode_a = 0;
    ready_mode_b = 0;

    repeat (4) @(negedge clk);
    check("end_queue_a", exp_a_q.size(), 0);
    check("end_queue_b", exp_b_q.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
